// File: rtl/logic_unit_arbiter.sv
// Two-requester sequencer/arbiter in front of a shared 32-bit bitwise logic unit.
// Define LOGIC_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [1:0]       lu_op,
  input  logic [WIDTH-1:0] lu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       last_grant;
  logic       grant0;
  logic       grant1;

  // A tie goes to whichever requester was not served last (or always to 0 in fixed mode).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
`else
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
`endif
  end

  assign req0_ready = (state == IDLE) && !reset && grant0;
  assign req1_ready = (state == IDLE) && !reset && grant1;
  assign rsp_valid  = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lu_a       <= '0;
      lu_b       <= '0;
      lu_op      <= 2'b00;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            lu_a       <= req0_a;
            lu_b       <= req0_b;
            lu_op      <= req0_op;
            rsp_id     <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (req1_ready) begin
            lu_a       <= req1_a;
            lu_b       <= req1_b;
            lu_op      <= req1_op;
            rsp_id     <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // The shared unit has had a full cycle on stable operands, so its result is settled here.
          rsp_data <= lu_out;
          rsp_zero <= (lu_out == '0);
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
